ascon_perm_ctrl_dom: RTL and testbench

Sequencer for the two-share DOM-protected ASCON permutation datapath. Per permutation request it loads the masked state, runs N rounds and drives the round-constant controls, passthrough enable and state-register enables. It also gates each round on a fresh 320-bit randomness word from the PRNG through a valid/ready handshake. Sits between the AEAD mode FSM (which issues requests) and the DOM datapath plus its state-share registers.

---
 rtl/ascon_dom_pkg.sv | 31 +++
 rtl/ascon_round_timer.sv | 35 +++
 rtl/ascon_perm_ctrl_dom.sv | 125 ++++++++++++
 tb/tb_ascon_perm_ctrl_dom.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_dom_pkg.sv
// Purpose: shared types and helpers for the DOM-masked ASCON permutation control.
// Latency: none; this package holds only types, constants and a combinational helper.
// Backpressure: not applicable.
package ascon_dom_pkg;

    localparam int MAX_ROUNDS = 12;

    // Round-constant command to the datapath.
    typedef enum logic [1:0] {
        RC_HOLD = 2'b00,
        RC_LOAD = 2'b01,
        RC_STEP = 2'b10
    } rcmode_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RWAIT,
        ROUND,
        DONE
    } perm_state_t;

    // A request of 0 rounds, or of more than a full p^a, means a full p^a.
    function automatic logic [3:0] nrounds_eff(input logic [3:0] n);
        if (n == 4'd0 || n > 4'(MAX_ROUNDS)) begin
            return 4'(MAX_ROUNDS);
        end
        return n;
    endfunction

endpackage

// File: rtl/ascon_round_timer.sv
// Purpose: phase counter for one DOM round, spanning RF_LAT cycles.
// Latency: flags are a decode of the registered phase; phase advances one step per cycle.
// Backpressure: none; it only counts while adv is high and returns to 0 on clr.
// Ports: clk/nRST clock and async active-low reset; clr forces phase 0;
//        adv steps the phase; last_ph marks phase RF_LAT-1; pre_last_ph marks RF_LAT-2.
module ascon_round_timer #(
    parameter int RF_LAT = 1
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic adv,
    output logic last_ph,
    output logic pre_last_ph
);

    localparam int PW = (RF_LAT > 1) ? $clog2(RF_LAT) : 1;

    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (adv) begin
            phase <= phase + PW'(1);
        end
    end

    assign last_ph = (phase == PW'(RF_LAT - 1));
    // With a single-stage round there is no cycle before the last one inside ROUND.
    assign pre_last_ph = (RF_LAT > 1) && (phase == PW'(RF_LAT - 2));

endmodule

// File: rtl/ascon_perm_ctrl_dom.sv
// Purpose: sequencer for the two-share DOM ASCON permutation (load, N masked rounds, done).
// Latency: 1 load cycle + nrounds_eff*(1+RF_LAT) cycles to done when randomness never stalls.
// Backpressure: each round waits in RWAIT until rand_valid; a stall adds cycles there only.
// Ports: start/nrounds request; rand_valid/rand_ready randomness handshake;
//        rcmode/constti/passthrough_en/state_sel/state_en drive datapath and share registers;
//        busy/done/round_cnt report progress.
module ascon_perm_ctrl_dom
    import ascon_dom_pkg::*;
#(
    parameter int RF_LAT = 1
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       start,
    input  logic [3:0] nrounds,
    input  logic       rand_valid,
    output logic       rand_ready,
    output rcmode_t    rcmode,
    output logic [3:0] constti,
    output logic       passthrough_en,
    output logic       state_sel,
    output logic       state_en,
    output logic       busy,
    output logic       done,
    output logic [3:0] round_cnt
);

    localparam bit ONE_STAGE = (RF_LAT == 1);

    perm_state_t state;
    logic [3:0]  nr_eff_q;
    logic [3:0]  nr_req_eff;
    logic        last_ph;
    logic        pre_last_ph;

    assign nr_req_eff = nrounds_eff(nrounds);

    // The PRNG word is consumed only while waiting for it.
    assign rand_ready = (state == RWAIT);

    ascon_round_timer #(
        .RF_LAT (RF_LAT)
    ) u_timer (
        .clk         (clk),
        .nRST        (nRST),
        .clr         (state != ROUND),
        .adv         ((state == ROUND) && !last_ph),
        .last_ph     (last_ph),
        .pre_last_ph (pre_last_ph)
    );

    // Outputs are registered, so the controls for the final round phase are set
    // on the edge that enters it: the transfer edge for a one-stage round, else
    // the edge leaving the second-to-last phase.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            nr_eff_q       <= 4'(MAX_ROUNDS);
            rcmode         <= RC_HOLD;
            constti        <= 4'd0;
            passthrough_en <= 1'b0;
            state_sel      <= 1'b0;
            state_en       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            round_cnt      <= 4'd0;
        end else begin
            rcmode         <= RC_HOLD;
            passthrough_en <= 1'b0;
            state_en       <= 1'b0;
            done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= LOAD;
                        nr_eff_q       <= nr_req_eff;
                        round_cnt      <= 4'd0;
                        busy           <= 1'b1;
                        rcmode         <= RC_LOAD;
                        constti        <= 4'(MAX_ROUNDS) - nr_req_eff;
                        passthrough_en <= 1'b1;
                        state_sel      <= 1'b0;
                        state_en       <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= RWAIT;
                end
                RWAIT: begin
                    if (rand_valid) begin
                        state <= ROUND;
                        if (ONE_STAGE) begin
                            rcmode    <= RC_STEP;
                            state_sel <= 1'b1;
                            state_en  <= 1'b1;
                        end
                    end
                end
                ROUND: begin
                    if (last_ph) begin
                        round_cnt <= round_cnt + 4'd1;
                        if (round_cnt + 4'd1 == nr_eff_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RWAIT;
                        end
                    end else if (pre_last_ph) begin
                        rcmode    <= RC_STEP;
                        state_sel <= 1'b1;
                        state_en  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl_dom.sv
// Purpose: scoreboard bench for ascon_perm_ctrl_dom with one-stage and three-stage rounds.
// Latency: expected cycle counts are hand-computed per request and queued at issue time.
// Backpressure: randomness stalls are driven per instance through rand_valid.
module tb_ascon_perm_ctrl_dom;
    import ascon_dom_pkg::*;

    typedef struct {
        int         d;
        logic [3:0] ct;
        int         n;
        int         lat;
    } exp_t;

    logic       clk;
    logic       nRST;
    logic [3:0] nr;
    logic       st [2];
    logic       rv [2];
    logic       rr [2];
    rcmode_t    rcm [2];
    logic [3:0] cti [2];
    logic       pt [2];
    logic       sel [2];
    logic       sen [2];
    logic       bsy [2];
    logic       dn [2];
    logic [3:0] rc [2];

    exp_t q[$];
    exp_t cur [2];
    bit   act [2];
    int   cyc [2];
    int   xf [2];
    int   se [2];
    int   bad [2];
    int   xcyc [2];
    bit   rst_seen;
    bit   end_req;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ascon_perm_ctrl_dom #(
            .RF_LAT (g == 0 ? 1 : 3)
        ) dut (
            .clk            (clk),
            .nRST           (nRST),
            .start          (st[g]),
            .nrounds        (nr),
            .rand_valid     (rv[g]),
            .rand_ready     (rr[g]),
            .rcmode         (rcm[g]),
            .constti        (cti[g]),
            .passthrough_en (pt[g]),
            .state_sel      (sel[g]),
            .state_en       (sen[g]),
            .busy           (bsy[g]),
            .done           (dn[g]),
            .round_cnt      (rc[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d want %0d", nm, d, got, want);
        end
    endtask

    // Monitor: samples on the falling edge, owns every comparison.
    always @(negedge clk) begin
        if (end_req) begin
            chk("queue_empty", 0, q.size(), 0);
            for (int d = 0; d < 2; d++) chk("idle_at_end", d, int'(act[d]), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end else if (!nRST) begin
            if (!rst_seen) begin
                rst_seen = 1'b1;
                for (int d = 0; d < 2; d++)
                    chk("reset_outputs", d,
                        int'({rr[d], rcm[d], cti[d], pt[d], sel[d], sen[d], bsy[d], dn[d], rc[d]}), 0);
            end
            for (int d = 0; d < 2; d++) begin
                if (act[d]) begin
                    act[d] = 1'b0;
                    chk("aborted_run_clean", d, bad[d], 0);
                end
            end
        end else begin
            rst_seen = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (!act[d]) begin
                    if (bsy[d]) begin
                        act[d] = 1'b1;
                        cyc[d] = 0; xf[d] = 0; se[d] = 0; bad[d] = 0; xcyc[d] = 0;
                        if (q.size() == 0) begin
                            chk("unexpected_start", d, 1, 0);
                            cur[d] = '{d: d, ct: 4'd0, n: 0, lat: 0};
                        end else begin
                            cur[d] = q.pop_front();
                        end
                        chk("load_dut_id", d, cur[d].d, d);
                        chk("load_controls", d,
                            int'({pt[d], sel[d], sen[d], rcm[d], cti[d], rr[d]}),
                            int'({1'b1, 1'b0, 1'b1, RC_LOAD, cur[d].ct, 1'b0}));
                    end
                end else begin
                    cyc[d]++;
                    if (rr[d] && rv[d]) begin
                        xf[d]++;
                        xcyc[d] = cyc[d];
                    end
                    if (sen[d]) begin
                        se[d]++;
                        if (!(rcm[d] == RC_STEP && sel[d] && !pt[d] && !rr[d] &&
                              (cyc[d] - xcyc[d]) == lat_of(d)))
                            bad[d]++;
                    end else if (rcm[d] != RC_HOLD || pt[d]) begin
                        bad[d]++;
                    end
                    if (dn[d]) begin
                        act[d] = 1'b0;
                        chk("latency", d, cyc[d], cur[d].lat);
                        chk("round_cnt", d, int'(rc[d]), cur[d].n);
                        chk("rand_transfers", d, xf[d], cur[d].n);
                        chk("state_en_pulses", d, se[d], cur[d].n);
                        chk("round_controls", d, bad[d], 0);
                        chk("busy_low_at_done", d, int'(bsy[d]), 0);
                    end else if (cyc[d] > 500) begin
                        act[d] = 1'b0;
                        chk("done_timeout", d, cyc[d], cur[d].lat);
                    end
                end
            end
        end
    end

    // Stimulus stays aligned to 1 time unit after each rising edge.
    task automatic issue(input int d, input logic [3:0] n, input logic [3:0] ct,
                         input int ne, input int lat);
        exp_t e;
        e = '{d: d, ct: ct, n: ne, lat: lat};
        q.push_back(e);
        nr = n;
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 600; i++) begin
            if (dn[d]) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rwait_at(input int d, input logic [3:0] r);
        for (int i = 0; i < 600; i++) begin
            if (rc[d] == r && rr[d]) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        nRST = 1'b0;
        nr = 4'd0;
        st[0] = 1'b0; st[1] = 1'b0;
        rv[0] = 1'b1; rv[1] = 1'b1;
        end_req = 1'b0;
        tests = 0;
        fails = 0;
        repeat (3) @(posedge clk);
        #1 nRST = 1'b1;
        @(posedge clk); #1;

        // Full p^a, six rounds, and the two clamped requests.
        issue(0, 4'd12, 4'd0, 12, 25);  wait_done(0);
        issue(0, 4'd6,  4'd6, 6, 13);   wait_done(0);
        issue(0, 4'd0,  4'd0, 12, 25);  wait_done(0);
        issue(0, 4'd15, 4'd0, 12, 25);  wait_done(0);

        // Three-cycle PRNG stall ahead of round 4.
        issue(0, 4'd12, 4'd0, 12, 28);
        wait_rwait_at(0, 4'd3);
        rv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rv[0] = 1'b1;
        wait_done(0);

        // Three-stage rounds.
        issue(1, 4'd8, 4'd4, 8, 33);    wait_done(1);

        // Ignored start mid-run, then asynchronous reset during round 5.
        issue(0, 4'd12, 4'd0, 12, 25);
        wait_rwait_at(0, 4'd4);
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        #2 nRST = 1'b0;
        @(posedge clk); #1;
        nRST = 1'b1;
        @(posedge clk); #1;

        issue(0, 4'd12, 4'd0, 12, 25);  wait_done(0);

        repeat (2) @(posedge clk);
        #1 end_req = 1'b1;
    end

endmodule
